gray_decoder_2bit: RTL
======================

GRAY_DECODER_2BIT -- requirements
Module: gray_decoder_2bit

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the signed position accumulator.
REQ-002 SHALL have parameter ERR_LIMIT, default 3: consecutive illegal steps that force FAULT (legal range 1..15).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have port gray_in  input  2: 2-bit Gray-coded sample from the 2-bit Gray counter sequence 00,01,11,10.
REQ-006 SHALL have port valid_in  input  1: gray_in is sampled on this cycle.
REQ-007 SHALL have port clr  input  1: synchronous clear to IDLE.
REQ-008 SHALL have port bin_out  output  2: binary value of the last accepted sample.
REQ-009 SHALL have port bin_valid  output  1: one-cycle pulse, bin_out updated.
REQ-010 SHALL have port dir  output  1: direction of the last legal step (1 = up, 0 = down).
REQ-011 SHALL have port step_err  output  1: one-cycle pulse on an illegal two-bit step.
REQ-012 SHALL have port count  output  CNT_W: signed position accumulator.
REQ-013 SHALL have port locked  output  1: high while in TRACK.
REQ-014 SHALL have port fault  output  1: high while in FAULT.

Function
REQ-015 SHALL decode Gray to binary: bin = {g[1], g[1]^g[0]}, so 00->0, 01->1, 11->2, 10->3.
REQ-016 SHALL register all outputs; effects of a sample on cycle N SHALL be visible after the rising edge ending cycle N (1-cycle latency).
REQ-017 SHALL implement an FSM with states IDLE, TRACK and FAULT.
REQ-018 IDLE + valid_in: SHALL store the sample as the reference, update bin_out, pulse bin_valid, leave count unchanged, and go to TRACK.
REQ-019 TRACK + valid_in, with delta = (new_bin - ref_bin) mod 4:
- 0: hold; pulse bin_valid; leave count and dir unchanged; clear err_cnt.
- 1: count+1; dir=1; clear err_cnt.
- 3: count-1; dir=0; clear err_cnt.
- 2: pulse step_err; leave count and dir unchanged; increment err_cnt.
REQ-020 Every accepted sample in TRACK (legal or illegal) SHALL update the reference and bin_out and pulse bin_valid.
REQ-021 When the increment from REQ-019 makes the internal consecutive-error counter equal ERR_LIMIT, the FSM SHALL move to FAULT on the same edge; step_err SHALL still pulse.
REQ-022 FAULT SHALL ignore valid_in; no bin_valid, no step_err, and no count change; outputs SHALL hold their values.
REQ-023 clr SHALL override valid_in in every state:
- next state IDLE
- count=0, err_cnt=0, dir=0, bin_out=0
- no pulses
REQ-024 count SHALL wrap modulo 2^CNT_W in two's complement: max positive +1 -> most negative, and 0 -1 -> all ones.
REQ-025 Cycles without valid_in and without clr SHALL change no state and produce no pulses.
REQ-026 locked SHALL equal (state==TRACK) and fault SHALL equal (state==FAULT), both registered.

Reset
REQ-027 reset_n low SHALL immediately force state IDLE and set bin_out, bin_valid, dir, step_err, count, locked, fault and err_cnt to 0, regardless of clk.
REQ-028 Deassertion of reset_n mid-sequence SHALL require a fresh first sample (IDLE) before any count change.

Verification
REQ-029 Reset then valid samples 00,01,11,10,00 -> bin_out 0,1,2,3,0; locked from the 1st sample; count 0,1,2,3,4; dir=1; no step_err.
REQ-030 In TRACK at count=4, samples 10,11,01 -> count 3,2,1; dir=0; bin_out 3,2,1.
REQ-031 Samples 00,11,00,11 (ERR_LIMIT=3) -> step_err on samples 2,3,4; fault=1 and locked=0 after the 4th sample; further valid_in is ignored.
REQ-032 Samples 00,11,01 -> step_err once; the 01 step from ref 11 is down (count -1) and clears err_cnt; a following 10 pulses step_err without reaching FAULT.
REQ-033 CNT_W=4, count=7 plus one up step -> count=4'b1000; from count=0 a down step -> 4'b1111.
REQ-034 clr and valid_in both high in TRACK -> IDLE, count=0, no bin_valid; reset_n pulsed low between clock edges mid-TRACK -> all outputs 0 immediately.

Source files
------------

// File: rtl/gray_decoder_2bit.sv
// 2-bit Gray-code position decoder: converts each accepted sample to binary,
// tracks direction and a wrapping signed position, and latches FAULT on repeated illegal steps.
module gray_decoder_2bit #(
   parameter int CNT_W     = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       gray_in,
   input  logic             valid_in,
   input  logic             clr,
   output logic [1:0]       bin_out,
   output logic             bin_valid,
   output logic             dir,
   output logic             step_err,
   output logic [CNT_W-1:0] count,
   output logic             locked,
   output logic             fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [3:0]       LIMIT     = 4'(ERR_LIMIT);

   state_t           r_state;
   logic [1:0]       r_bin;
   logic             r_bin_valid;
   logic             r_dir;
   logic             r_step_err;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_err_cnt;
   logic             r_locked;
   logic             r_fault;

   logic [1:0]       w_bin;
   logic [1:0]       w_delta;
   logic [3:0]       w_err_inc;

   // r_bin doubles as the reference for the next step: it always holds the last accepted sample.
   assign w_bin     = {gray_in[1], gray_in[1] ^ gray_in[0]};
   assign w_delta   = w_bin - r_bin;
   assign w_err_inc = r_err_cnt + 4'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_bin       <= 2'd0;
         r_bin_valid <= 1'b0;
         r_dir       <= 1'b0;
         r_step_err  <= 1'b0;
         r_count     <= '0;
         r_err_cnt   <= 4'd0;
         r_locked    <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch sees the pre-edge state;
         // the pulses are defaulted low here and only raised by an accepted sample.
         r_bin_valid <= 1'b0;
         r_step_err  <= 1'b0;

         if (clr) begin
            r_state   <= S_IDLE;
            r_bin     <= 2'd0;
            r_dir     <= 1'b0;
            r_count   <= '0;
            r_err_cnt <= 4'd0;
            r_locked  <= 1'b0;
            r_fault   <= 1'b0;
         end else if (valid_in) begin
            case (r_state)
               S_IDLE: begin
                  r_bin       <= w_bin;
                  r_bin_valid <= 1'b1;
                  r_err_cnt   <= 4'd0;
                  r_state     <= S_TRACK;
                  r_locked    <= 1'b1;
               end
               S_TRACK: begin
                  r_bin       <= w_bin;
                  r_bin_valid <= 1'b1;
                  case (w_delta)
                     2'd0: r_err_cnt <= 4'd0;
                     2'd1: begin
                        r_count   <= r_count + CNT_ONE;
                        r_dir     <= 1'b1;
                        r_err_cnt <= 4'd0;
                     end
                     2'd3: begin
                        r_count   <= r_count - CNT_ONE;
                        r_dir     <= 1'b0;
                        r_err_cnt <= 4'd0;
                     end
                     default: begin
                        // Both bits flipped: direction is unknowable, so only flag it.
                        r_step_err <= 1'b1;
                        r_err_cnt  <= w_err_inc;
                        if (w_err_inc == LIMIT) begin
                           r_state  <= S_FAULT;
                           r_locked <= 1'b0;
                           r_fault  <= 1'b1;
                        end
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign bin_out   = r_bin;
   assign bin_valid = r_bin_valid;
   assign dir       = r_dir;
   assign step_err  = r_step_err;
   assign count     = r_count;
   assign locked    = r_locked;
   assign fault     = r_fault;

endmodule
